fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of decode; owns the PC and the instruction-memory request/response handshake.
//  Presents fetched {pc, inst} to the decode pipeline register through a 2-entry buffer.
//  Obeys stall_fetch from the hazard unit and takes branch/jump redirects.
//  Allows one outstanding imem request; drops stale responses after a redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  XLEN       32             address/instruction width
// PORTS
//  clk             in   1     single clock; all state updates on rising edge
//  reset           in   1     asynchronous, active-low reset
//  stall_fetch     in   1     hazard-unit stall; decode does not consume this cycle
//  redirect_valid  in   1     taken branch/jump resolved
//  redirect_pc     in   XLEN  redirect target; bits[1:0] ignored (forced 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request (handshake = valid & ready)
//  imem_req_addr   out  XLEN  fetch address (word aligned)
//  imem_rsp_valid  in   1     response valid; one per accepted request, >=1 cycle after it
//  imem_rsp_data   in   XLEN  instruction word
//  f_valid         out  1     head buffer entry valid toward decode
//  f_pc            out  XLEN  head entry PC
//  f_inst          out  XLEN  head entry instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, buffer empty. Outputs: imem_req_valid=0, f_valid=0, f_pc=0, f_inst=0.
//   imem_req_addr=RESET_PC.
//  FSM states:
//   IDLE  no request outstanding. imem_req_valid=1 iff occupancy<2. On accept -> WAIT.
//   WAIT  one request outstanding.
//     rsp: push {pc_of_req, data}; pc+=4; -> IDLE.
//   KILL  outstanding response is stale. Next rsp is discarded -> IDLE.
//  Issue rule: occupancy + outstanding <= 2 at all times; never request if a response could overflow.
//  Consume: head popped on any cycle with f_valid & !stall_fetch; push and pop in one cycle are legal.
//  Buffer ordering is FIFO. f_* are registered and show the head entry.
//  With the buffer empty, a response becomes visible on f_valid the following cycle.
//  Redirect (priority over stall, push, pop):
//   - Buffer is flushed (f_valid=0 next cycle) and pc<=redirect_pc.
//   - If WAIT, or a request is accepted in the same cycle: -> KILL. Otherwise -> IDLE.
//   - A response arriving in the redirect cycle is discarded. From WAIT the next state is IDLE, not KILL.
//   - Target is requested no earlier than the cycle after the redirect (or after the KILL response).
//  pc arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
//  Stall: buffer holds and f_* stay stable. Requests continue while there is space.
//  imem_req_addr stable while imem_req_valid & !imem_req_ready; the request is never withdrawn except by redirect/reset.
//  Reset mid-operation: all state is cleared immediately. An in-flight response after reset is not tracked.
//   The memory side must be reset together with this block.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds output perf_fetch_stall_cnt [31:0].
//   Counts cycles in which f_valid=0 and stall_fetch=0 (decode starved). Reset 0; saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//  1 Reset release, req_ready=1, 1-cycle rsp -> first req addr 0x0. Then 0x4, 0x8.
//    f_pc sequence 0x0,0x4,0x8 with f_valid continuous after fill.
//  2 stall_fetch=1 for 5 cycles at f_pc=0x8 -> f_* frozen. At most 2 entries buffered.
//    No request issued while occupancy+outstanding==2. Release -> 0xC, 0x10 in order.
//  3 redirect_valid, redirect_pc=0x100 while WAIT -> KILL. Late response for the old pc is dropped.
//    Next f_pc=0x100, no stale inst.
//  4 redirect_pc=0x203 together with a response -> response dropped, req addr 0x200.
//  5 req_ready held 0 for 4 cycles -> imem_req_addr stable. Reset asserted mid-WAIT -> outputs at reset values.
//    Next req addr RESET_PC.
//  6 pc=0xFFFF_FFFC -> following req addr 0x0. With FETCH_PERF_CNT_EN: 3 starved cycles -> counter=3.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, single-outstanding imem handshake, 2-entry {pc,inst} buffer
// Optional decode-starvation counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_fetch,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            f_valid,
    output logic [XLEN-1:0] f_pc,
    output logic [XLEN-1:0] f_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic [1:0]      count_q, count_d, count_tmp;
    logic [XLEN-1:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
    logic [XLEN-1:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;
    logic            accept, pop, push;

    assign accept = req_valid_q & imem_req_ready;
    assign pop    = (count_q != 2'd0) & ~stall_fetch;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        push      = 1'b0;
        e0_pc_d   = e0_pc_q;
        e0_inst_d = e0_inst_q;
        e1_pc_d   = e1_pc_q;
        e1_inst_d = e1_inst_q;
        count_tmp = count_q;

        case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: if (imem_rsp_valid) begin
                push    = 1'b1;
                pc_d    = pc_q + XLEN'(4);
                state_d = IDLE;
            end
            KILL: if (imem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pop shifts the tail into the head; the push then lands in the first free slot.
        if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            count_tmp = count_q - 2'd1;
        end
        if (push) begin
            if (count_tmp == 2'd0) begin
                e0_pc_d   = pc_q;
                e0_inst_d = imem_rsp_data;
            end else begin
                e1_pc_d   = pc_q;
                e1_inst_d = imem_rsp_data;
            end
            count_tmp = count_tmp + 2'd1;
        end
        count_d = count_tmp;

        if (redirect_valid) begin
            count_d = 2'd0;
            pc_d    = redirect_pc & ~XLEN'(3);
            if (accept || ((state_q != IDLE) && !imem_rsp_valid))
                state_d = KILL;
            else
                state_d = IDLE;
        end

        // Only request when a response is guaranteed a free slot.
        req_valid_d = (state_d == IDLE) && (count_d < 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            count_q     <= 2'd0;
            e0_pc_q     <= '0;
            e0_inst_q   <= '0;
            e1_pc_q     <= '0;
            e1_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            count_q     <= count_d;
            e0_pc_q     <= e0_pc_d;
            e0_inst_q   <= e0_inst_d;
            e1_pc_q     <= e1_pc_d;
            e1_inst_q   <= e1_inst_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign f_valid        = (count_q != 2'd0);
    assign f_pc           = e0_pc_q;
    assign f_inst         = e0_inst_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!f_valid && !stall_fetch && (perf_q != 32'hFFFF_FFFF))
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= 32'd0;
        else        perf_q <= perf_d;
    end

    assign perf_fetch_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed, table-driven bench for fetch_unit
// Honours FETCH_PERF_CNT_EN to exercise the starvation counter.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_stall_cnt;
    int          perf_exp = 0;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall_fetch(stall_fetch),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .f_valid(f_valid), .f_pc(f_pc),
        .f_inst(f_inst)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_stall_cnt(perf_fetch_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: samples the request handshake mid-cycle, answers rsp_lat cycles later.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    int          rsp_lat = 0;
    logic [31:0] last_acc = '0;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_wait == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = inst_of(pend_addr);
                        pend = 1'b0;
                    end else begin
                        pend_wait--;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend      = 1'b1;
                    pend_addr = imem_req_addr;
                    pend_wait = rsp_lat;
                    last_acc  = imem_req_addr;
                end
            end
`ifdef FETCH_PERF_CNT_EN
            if (!reset) perf_exp = 0;
            else if (!f_valid && !stall_fetch) perf_exp++;
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pop_expect(input logic [31:0] pc);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (f_valid) begin
                check("f_pc", f_pc, pc);
                check("f_inst", f_inst, inst_of(pc));
                got = 1'b1;
            end
            step();
        end
        if (!got) check("pop_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pend(input int lo, input int hi);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (pend && pend_wait >= lo && pend_wait <= hi) got = 1'b1;
            else step();
        end
        if (!got) check("wait_pend_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          kill;
        logic [31:0] target;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{1'b0, 32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
        vecs[4] = '{1'b0, 32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};

        reset = 1'b0; stall_fetch = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_req_ready = 1'b1;
        step(); step();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_f_valid", {31'd0, f_valid}, 32'd0);
        check("rst_f_pc", f_pc, 32'h0);
        check("rst_f_inst", f_inst, 32'h0);
        reset = 1'b1;

        // Sequential fetch from reset.
        pop_expect(32'h0);
        pop_expect(32'h4);

        // Stall with 0x8 at the head: head frozen, buffer fills to two, requests stop.
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (f_valid) seen = 1'b1; else step();
            end
            if (!seen) check("stall_wait_timeout", 32'd0, 32'd1);
        end
        stall_fetch = 1'b1;
        check("stall_head", f_pc, 32'h8);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_f_pc", f_pc, 32'h8);
            check("stall_f_valid", {31'd0, f_valid}, 32'd1);
        end
        step(); step(); step();
        check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("stall_last_acc", last_acc, 32'hC);
        stall_fetch = 1'b0;
        pop_expect(32'h8);
        pop_expect(32'hC);
        pop_expect(32'h10);

        // Redirects: kill rows land mid-WAIT, others land on the response cycle.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].kill) begin
                rsp_lat = 3;
                wait_pend(2, 100);
            end else begin
                rsp_lat = 0;
                wait_pend(0, 0);
            end
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].target;
            step();
            redirect_valid = 1'b0;
            check("redir_flush", {31'd0, f_valid}, 32'd0);
            check("redir_addr", imem_req_addr, vecs[v].exp0);
            if (vecs[v].kill)
                check("kill_no_req", {31'd0, imem_req_valid}, 32'd0);
            pop_expect(vecs[v].exp0);
            pop_expect(vecs[v].exp1);
            rsp_lat = 0;
        end

        // Back-pressure: request held stable while not accepted.
        imem_req_ready = 1'b0;
        begin
            bit seen = 1'b0;
            logic [31:0] held;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (imem_req_valid) seen = 1'b1; else step();
            end
            if (!seen) check("bp_wait_timeout", 32'd0, 32'd1);
            held = imem_req_addr;
            for (int i = 0; i < 4; i++) begin
                step();
                check("bp_valid", {31'd0, imem_req_valid}, 32'd1);
                check("bp_addr", imem_req_addr, held);
            end
        end
        imem_req_ready = 1'b1;

        // Reset mid-WAIT: outputs clear immediately, fetch restarts at RESET_PC.
        wait_pend(0, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mid_rst_req_addr", imem_req_addr, 32'h0);
        check("mid_rst_f_valid", {31'd0, f_valid}, 32'd0);
        check("mid_rst_f_pc", f_pc, 32'h0);
        step();
        reset = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                if (f_valid) seen = 1'b1; else step();
            end
            if (!seen) check("restart_timeout", 32'd0, 32'd1);
`ifdef FETCH_PERF_CNT_EN
            check("perf_starved3", perf_fetch_stall_cnt, 32'd3);
`endif
        end
        pop_expect(32'h0);
        pop_expect(32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("perf_model", perf_fetch_stall_cnt, perf_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
